// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: sequencer state
// encoding and default datapath widths.
package alu_arbiter_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_CTRL_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, and on contention the
// requester that did not win last time gets the grant.
module alu_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = valid0 | valid1;
    assign grant_id    = (valid0 & valid1) ? ~last : valid1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Runs an IDLE/EXEC/RESP sequencer with registered operands and result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CTRL_W = DEFAULT_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_in1,
    input  logic [WIDTH-1:0]  req0_in2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_in1,
    input  logic [WIDTH-1:0]  req1_in2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              zero_flag,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [WIDTH-1:0]  resp_result,
    output logic              resp_zero,
    output logic              busy,
    output logic              grant_id
);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic [WIDTH-1:0]  op1_q, op1_d;
    logic [WIDTH-1:0]  op2_q, op2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;

    logic pick_valid;
    logic pick_id;
    logic in_idle;
    logic resp_taken;

    alu_rr_pick u_pick (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last        (last_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    assign in_idle    = (state_q == ST_IDLE);
    assign req0_ready = in_idle & pick_valid & ~pick_id;
    assign req1_ready = in_idle & pick_valid &  pick_id;
    assign resp_taken = grant_q ? resp1_ready : resp0_ready;

    always_comb begin
        // NOTE: every next-state signal holds its register value by default,
        // so no branch below can leave one unassigned and infer a latch.
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_EXEC;
                    grant_d = pick_id;
                    last_d  = pick_id;
                    op1_d   = pick_id ? req1_in1  : req0_in1;
                    op2_d   = pick_id ? req1_in2  : req0_in2;
                    ctrl_d  = pick_id ? req1_ctrl : req0_ctrl;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                zero_d   = zero_flag;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_taken) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign alu_in1     = op1_q;
    assign alu_in2     = op2_q;
    assign alu_control = ctrl_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign grant_id    = grant_q;
    assign busy        = ~in_idle;
    assign resp0_valid = (state_q == ST_RESP) & ~grant_q;
    assign resp1_valid = (state_q == ST_RESP) &  grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a small reference ALU
// (0000 add, 0001 sub, 0010 or, 0011 and, others xor).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_control;
    logic        zero_flag;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_result;
    logic        resp_zero, busy, grant_id;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_in1    (req0_in1),
        .req0_in2    (req0_in2),
        .req0_ctrl   (req0_ctrl),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_in1    (req1_in1),
        .req1_in2    (req1_in2),
        .req1_ctrl   (req1_ctrl),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_in1 + alu_in2;
            4'b0001: alu_result = alu_in1 - alu_in2;
            4'b0010: alu_result = alu_in1 | alu_in2;
            4'b0011: alu_result = alu_in1 & alu_in2;
            default: alu_result = alu_in1 ^ alu_in2;
        endcase
    end
    assign zero_flag = (alu_result == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [31:0] res, input logic zero);
        exp_t e;
        e.id   = id;
        e.res  = res;
        e.zero = zero;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
        if (id) begin
            req1_valid = v; req1_in1 = a; req1_in2 = b; req1_ctrl = c;
        end else begin
            req0_valid = v; req0_in1 = a; req0_in2 = b; req0_ctrl = c;
        end
    endtask

    function automatic logic rdy(input logic id);
        return id ? req1_ready : req0_ready;
    endfunction

    // Drive one request and return one time unit after the accepting edge.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
        int n = 0;
        set_req(id, 1'b1, a, b, c);
        @(negedge clk);
        while (!rdy(id) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", rdy(id), 1);
        chk("loser_ready", id ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input logic id);
        int n = 0;
        @(negedge clk);
        while (!(id ? resp1_valid : resp0_valid) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", id ? resp1_valid : resp0_valid, 1);
        chk("grant_id", grant_id, id);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_rdy"}, {req0_ready, req1_ready}, 0);
        chk({tag, "_rvalid"}, {resp0_valid, resp1_valid}, 0);
        chk({tag, "_in1"}, alu_in1, 0);
        chk({tag, "_in2"}, alu_in2, 0);
        chk({tag, "_ctrl"}, alu_control, 0);
        chk({tag, "_result"}, resp_result, 0);
        chk({tag, "_zero"}, resp_zero, 0);
    endtask

    // Response monitor: each handshake pops the scoreboard in order.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            exp_t e;
            chk("resp_onehot", resp0_valid & resp1_valid, 0);
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                chk("resp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("resp_port", resp1_valid, e.id);
                    chk("resp_result", resp_result, e.res);
                    chk("resp_zero", resp_zero, e.zero);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("por");

        // Single request: 8 - 10 with explicit cycle-by-cycle timing.
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'd8, 32'd10, 4'b0001);
        push(0, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        chk("single_rdy0", req0_ready, 1);
        chk("single_rdy1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_busy", busy, 1);
        chk("single_in1", alu_in1, 32'd8);
        chk("single_in2", alu_in2, 32'd10);
        chk("single_ctrl", alu_control, 4'b0001);
        chk("single_early", resp0_valid, 0);
        chk("single_rdy_exec", req0_ready, 0);
        @(negedge clk);
        chk("single_rv0", resp0_valid, 1);
        chk("single_rv1", resp1_valid, 0);
        chk("single_res", resp_result, 32'hFFFF_FFFE);
        chk("single_zero", resp_zero, 0);
        @(negedge clk);
        chk("single_rv0_fall", resp0_valid, 0);
        chk("single_idle", busy, 0);
        drain();

        // Zero flag on requester 1.
        push(1, 32'd0, 1'b1);
        issue(1, 32'd10, 32'd10, 4'b0001);
        wait_resp(1);
        chk("zero_flag", resp_zero, 1);
        drain();

        // Backpressure: resp0 stalled while req1 waits.
        resp0_ready = 1'b0;
        set_req(1, 1'b1, 32'd1, 32'd2, 4'b0000);
        push(0, 32'hFFFF_FFFE, 1'b0);
        push(1, 32'd3, 1'b0);
        issue(0, 32'd8, 32'd10, 4'b0001);
        wait_resp(0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp0_valid, 1);
            chk("bp_result", resp_result, 32'hFFFF_FFFE);
            chk("bp_busy", busy, 1);
            chk("bp_rdy1", req1_ready, 0);
            @(posedge clk); #1;
            if (i == 4) resp0_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_hs_rdy1", req1_ready, 0);
        @(negedge clk);
        chk("bp_after_rdy1", req1_ready, 1);
        chk("bp_after_busy", busy, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp(1);
        drain();

        // Reset during EXEC aborts the transaction.
        set_req(0, 1'b1, 32'd8, 32'd10, 4'b0011);
        @(negedge clk);
        chk("rst_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_exec", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {resp0_valid, resp1_valid}, 0);
        end
        @(posedge clk); #1;

        // Contention after reset: grants alternate 0,1,0,1.
        push(0, 32'd8, 1'b0);
        push(1, 32'd5, 1'b0);
        push(0, 32'd8, 1'b0);
        push(1, 32'd5, 1'b0);
        set_req(0, 1'b1, 32'd5, 32'd3, 4'b0000);
        set_req(1, 1'b1, 32'd7, 32'd2, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("cont_grant0", req0_ready, (k % 2) == 0);
            chk("cont_grant1", req1_ready, (k % 2) == 1);
            @(posedge clk); #1;
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        drain();

        // Payload stability: operand change after acceptance is ignored.
        push(0, 32'd8, 1'b0);
        issue(0, 32'd8, 32'd10, 4'b0011);
        req0_in1 = 32'd0;
        @(negedge clk);
        chk("stable_in1", alu_in1, 32'd8);
        wait_resp(0);
        chk("stable_res", resp_result, 32'd8);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
